// File: rtl/digit_matcher.sv
// digit_matcher: scans every stored 16x16 digit template row by row against
// the captured canvas and reports the template with the smallest Hamming
// distance, plus a confidence flag against a fixed threshold.
module digit_matcher #(
  parameter int NUM_TEMPLATES = 10,
  parameter int MATCH_THRESH  = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  row_addr,
  output logic [3:0]  tmpl_sel,
  input  logic [15:0] tmpl_row,
  input  logic [15:0] canvas_row,
  output logic        busy,
  output logic        done,
  output logic [3:0]  result_digit,
  output logic [8:0]  result_score,
  output logic        result_match
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_TMPL = 4'(NUM_TEMPLATES - 1);
  localparam logic [8:0] THRESH    = 9'(MATCH_THRESH);

  state_t      state, state_next;
  logic [8:0]  acc;
  logic [8:0]  best_score;
  logic [3:0]  best_digit;
  logic [15:0] row_diff;
  logic [4:0]  row_dist;
  logic [8:0]  total;
  logic        better;
  logic [8:0]  final_score;
  logic [3:0]  final_digit;
  logic        row_last;
  logic        tmpl_last;

  // Row distance and running best, including the template currently finishing.
  always_comb begin
    row_diff = tmpl_row ^ canvas_row;
    row_dist = '0;
    for (int i = 0; i < 16; i++) begin
      row_dist = row_dist + 5'(row_diff[i]);
    end
    total       = acc + {4'b0, row_dist};
    better      = (total < best_score);
    final_score = better ? total : best_score;
    final_digit = better ? tmpl_sel : best_digit;
    row_last    = (row_addr == 4'hF);
    tmpl_last   = (tmpl_sel == LAST_TMPL);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status decode from the registered state.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (row_last && tmpl_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address walk, score accumulation and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_addr     <= '0;
      tmpl_sel     <= '0;
      acc          <= '0;
      best_score   <= 9'h1FF;
      best_digit   <= '0;
      result_digit <= '0;
      result_score <= '0;
      result_match <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_addr   <= '0;
            tmpl_sel   <= '0;
            acc        <= '0;
            best_score <= 9'h1FF;
            best_digit <= '0;
          end
        end
        SCAN: begin
          if (!row_last) begin
            acc      <= total;
            row_addr <= row_addr + 4'd1;
          end else begin
            // Template boundary: fold this template into the running best.
            best_score <= final_score;
            best_digit <= final_digit;
            acc        <= '0;
            row_addr   <= '0;
            if (tmpl_last) begin
              tmpl_sel     <= '0;
              result_digit <= final_digit;
              result_score <= final_score;
              result_match <= (final_score <= THRESH);
            end else begin
              tmpl_sel <= tmpl_sel + 4'd1;
            end
          end
        end
        DONE: begin
          row_addr <= '0;
          tmpl_sel <= '0;
        end
        default: begin
          row_addr <= '0;
          tmpl_sel <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/digit_matcher.md
# digit_matcher

Template-matching reader for the number-recognition datapath. On `start`, it walks every row of every stored 16x16 digit template and reads the same row of the user's captured 16x16 canvas. It scores each template by Hamming distance (popcount of the row XOR, summed over 16 rows) and reports the digit with the lowest score. It sits between the canvas bitmap store and the bank of digit template ROMs, and drives the shared row address into both.

## Interface
- `NUM_TEMPLATES`, default 10: number of templates scanned, indices 0..NUM_TEMPLATES-1; legal range 2..16.
- `MATCH_THRESH`, default 40: maximum score that still counts as a confident match.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- `row_addr`  out  4  registered row index; drives the template ROM `addr` and the canvas read address.
- `tmpl_sel`  out  4  registered template index; selects which ROM row feeds `tmpl_row` through an external mux.
- `tmpl_row`  in  16  template row; bit 0 = leftmost pixel; combinational from `row_addr`/`tmpl_sel`.
- `canvas_row`  in  16  canvas row at `row_addr`; combinational, same bit order.
- `busy`  out  1  high while scanning.
- `done`  out  1  one-cycle pulse when the result registers update.
- `result_digit`  out  4  index of the best template.
- `result_score`  out  9  Hamming distance of the best template, 0..256.
- `result_match`  out  1  1 when `result_score` <= MATCH_THRESH.

## Operation
- FSM with three states: IDLE, SCAN, DONE.
  - IDLE to SCAN when `start`=1. On that edge: `row_addr`=0, `tmpl_sel`=0, accumulator=0, best_score=9'h1FF, best_digit=0.
  - SCAN, per cycle: `d` = popcount(`tmpl_row` ^ `canvas_row`), a value from 0 to 16, computed combinationally.
    - If `row_addr` != 15: accumulator += `d`; `row_addr`++.
    - If `row_addr` == 15: total = accumulator + `d`, 9 bits, no overflow possible.
      - If total < best_score (strictly less), best_score = total and best_digit = `tmpl_sel`. On a tie the lower index wins.
      - Clear the accumulator, set `row_addr` = 0, increment `tmpl_sel`.
    - SCAN to DONE on the edge that finishes row 15 of template NUM_TEMPLATES-1. On that same edge, load `result_digit`/`result_score`/`result_match` from the final best values, including that template's own comparison.
  - DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `start` is ignored in SCAN and DONE. It does not queue.
- Result registers hold their value until the next DONE. They are not cleared by `start`.
- `busy` = (state == SCAN), decoded from registered state.
- `row_addr` and `tmpl_sel` are 0 in IDLE and DONE.

## Timing
- Reset (`rst_n`=0, asynchronous) sets: state IDLE, `row_addr`=0, `tmpl_sel`=0, `busy`=0, `done`=0, `result_digit`=0, `result_score`=0, `result_match`=0, accumulator=0.
- Reset during SCAN aborts the scan immediately, with no `done` pulse.
- Template and canvas reads are combinational: data for the registered address is consumed in the same cycle. No read latency is tolerated.
- Latency: with `start` sampled at edge E0, SCAN occupies 16*NUM_TEMPLATES cycles (160 by default). `done` is high in the cycle after edge E0+160, and results are valid from that same edge.
- Minimum start-to-start period is 16*NUM_TEMPLATES + 2 cycles, i.e. 162.
- Wrap-around: `tmpl_sel` never exceeds NUM_TEMPLATES-1 while `busy`. `row_addr` wraps 15 to 0 only on a template boundary.

## Test plan
- Canvas = template 7 exactly; pulse `start` -> `busy` for 160 cycles, `done` in cycle 161, `result_digit`=7, `result_score`=0, `result_match`=1.
- Canvas = template 3 with 5 pixels flipped (all other templates at distance >10) -> `result_digit`=3, `result_score`=5, `result_match`=1.
- Bench templates 2 and 5 identical and both matching the canvas exactly -> `result_digit`=2, confirming the tie goes to the lowest index.
- All templates all-zero, canvas all-ones -> `result_digit`=0, `result_score`=256, `result_match`=0, confirming the 9-bit width.
- `start` re-pulsed at cycle 50 of a scan -> no restart; `done` still at cycle 161. A second `start` after DONE gives correct new results.
- `rst_n` low at cycle 80 of a scan -> outputs at their reset values immediately, and no `done` pulse. A fresh `start` then completes normally.
